// File: rtl/pulse_train.sv
// rtl/pulse_train.sv - multi-channel pulse train generator with per-channel shadowed settings
// Optional PULSE_TRAIN_RETRIGGER_EN: start while busy restarts the train with fresh settings.
module pulse_train #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH_BITS = 16,
    parameter int COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   start,
    input  logic [CHANNELS-1:0]   stop,
    input  logic [WIDTH_BITS-1:0] width,
    input  logic [WIDTH_BITS-1:0] period,
    input  logic [COUNT_BITS-1:0] n_pulses,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   busy,
    output logic [CHANNELS-1:0]   done
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    localparam logic [WIDTH_BITS-1:0] W_ONE = WIDTH_BITS'(1);
    localparam logic [COUNT_BITS-1:0] C_ONE = COUNT_BITS'(1);

    // Low time is stored directly as P-W so the widest W never needs P=W+1 in WIDTH_BITS.
    logic [WIDTH_BITS-1:0] w_cap;
    logic [WIDTH_BITS-1:0] lo_cap;

    always_comb begin
        w_cap  = (width == '0) ? W_ONE : width;
        lo_cap = (period > w_cap) ? (period - w_cap) : W_ONE;
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t                state;
        state_t                state_nxt;
        logic [WIDTH_BITS-1:0] phase;
        logic [WIDTH_BITS-1:0] w_sh;
        logic [WIDTH_BITS-1:0] lo_sh;
        logic [COUNT_BITS-1:0] cnt;
        logic [COUNT_BITS-1:0] n_sh;
        logic                  load;
        logic                  phase_end;
        logic                  last;
        logic                  pulse_d, busy_d, done_d;
        logic                  pulse_q, busy_q, done_q;

`ifdef PULSE_TRAIN_RETRIGGER_EN
        assign load = start[gi] && !stop[gi];
`else
        assign load = start[gi] && !stop[gi] && (state == S_IDLE);
`endif

        assign phase_end = (state == S_HIGH) ? (phase == w_sh - W_ONE)
                                             : (phase == lo_sh - W_ONE);
        assign last      = (n_sh != '0) && (cnt == n_sh - C_ONE);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state   <= S_IDLE;
                phase   <= '0;
                cnt     <= '0;
                w_sh    <= '0;
                lo_sh   <= '0;
                n_sh    <= '0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state   <= state_nxt;
                pulse_q <= pulse_d;
                busy_q  <= busy_d;
                done_q  <= done_d;
                if (load || (state_nxt != state)) begin
                    phase <= '0;
                end else if (state != S_IDLE) begin
                    phase <= phase + W_ONE;
                end
                if (load) begin
                    w_sh  <= w_cap;
                    lo_sh <= lo_cap;
                    n_sh  <= n_pulses;
                    cnt   <= '0;
                end else if ((state == S_HIGH) && phase_end && (n_sh != '0)) begin
                    cnt <= cnt + C_ONE;
                end
            end
        end

        always_comb begin
            state_nxt = state;
            if (stop[gi] && (state != S_IDLE)) begin
                state_nxt = S_IDLE;
            end else if (load) begin
                state_nxt = S_HIGH;
            end else begin
                case (state)
                    S_HIGH:  if (phase_end) state_nxt = last ? S_IDLE : S_LOW;
                    S_LOW:   if (phase_end) state_nxt = S_HIGH;
                    default: state_nxt = state;
                endcase
            end
        end

        // Outputs are decoded from the next state and registered, so pins see clean flops.
        always_comb begin
            pulse_d = (state_nxt == S_HIGH);
            busy_d  = (state_nxt != S_IDLE);
            done_d  = (state == S_HIGH) && phase_end && last && !stop[gi] && !load;
        end

        assign pulse[gi] = pulse_q;
        assign busy[gi]  = busy_q;
        assign done[gi]  = done_q;
    end

endmodule

// File: tb/tb_pulse_train.sv
// tb/tb_pulse_train.sv - randomized self-checking bench for pulse_train against a timeline model
module tb_pulse_train;

    localparam int NCH = 4;
`ifdef PULSE_TRAIN_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  start = '0;
    logic [NCH-1:0]  stop = '0;
    logic [15:0]     width = '0;
    logic [15:0]     period = '0;
    logic [7:0]      n_pulses = '0;
    logic [NCH-1:0]  pulse, busy, done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: a running train is described only by its capture cycle and its W, P, N.
    bit             m_act [NCH];
    int             m_k [NCH];
    int             m_w [NCH];
    int             m_p [NCH];
    int             m_n [NCH];
    logic [NCH-1:0] ep = '0, eb = '0, ed = '0;

    pulse_train dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .width(width), .period(period), .n_pulses(n_pulses),
        .pulse(pulse), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) m_act[c] = 1'b0;
        ep = '0; eb = '0; ed = '0;
    endtask

    task automatic model_edge();
        int t, last_end;
        for (int c = 0; c < NCH; c++) begin
            if (stop[c] && eb[c]) begin
                m_act[c] = 1'b0;
            end else if (start[c] && !stop[c] && (!eb[c] || RETRIG)) begin
                m_act[c] = 1'b1;
                m_k[c]   = cyc;
                m_w[c]   = (width == 0) ? 1 : int'(width);
                m_p[c]   = (int'(period) > m_w[c]) ? int'(period) : m_w[c] + 1;
                m_n[c]   = int'(n_pulses);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            ep[c] = 1'b0; eb[c] = 1'b0; ed[c] = 1'b0;
            if (m_act[c]) begin
                t = cyc - m_k[c];
                last_end = (m_n[c] - 1) * m_p[c] + m_w[c];
                if (m_n[c] != 0 && t >= last_end) begin
                    ed[c] = (t == last_end);
                    m_act[c] = 1'b0;
                end else begin
                    eb[c] = 1'b1;
                    ep[c] = ((t % m_p[c]) < m_w[c]);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst) model_edge();
        #1;
    endtask

    task automatic test_reset();
        int t0;
        tick(); tick();
        checks++;
        if ({pulse, busy, done} !== 12'h000) begin
            failures++;
            $display("FAIL reset_hold got=%b/%b/%b want=0/0/0", pulse, busy, done);
        end
        tick();
        rst = 1'b0;
        model_reset();
        width = 16'd3; period = 16'd8; n_pulses = 8'd5; start[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            start[0] = 1'b0;
            checks++;
            if (pulse !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL reset_pre cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc, pulse, busy, done, ep, eb, ed);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pulse, busy, done} !== 12'h000) begin
            failures++;
            $display("FAIL reset_async got=%b/%b/%b want=0/0/0", pulse, busy, done);
        end
        model_reset();
        tick();
        rst = 1'b0;
        start[0] = 1'b1;
        t0 = cyc + 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            start[0] = 1'b0;
            checks++;
            if (pulse !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL reset_restart cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc, pulse, busy, done, ep, eb, ed);
            end
            if (cyc == t0) begin
                checks++;
                if (pulse[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_first_start got=%b want=1", pulse[0]);
                end
            end
        end
    endtask

    task automatic test_basic();
        int k0, dcyc, highs;
        dcyc = -1; highs = 0;
        width = 16'd3; period = 16'd8; n_pulses = 8'd4; start[1] = 1'b1;
        tick();
        k0 = cyc;
        start[1] = 1'b0;
        width = 16'($urandom); period = 16'($urandom); n_pulses = 8'($urandom);
        for (int i = 0; i < 34; i++) begin
            checks++;
            if (pulse !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc, pulse, busy, done, ep, eb, ed);
            end
            if (pulse[1]) highs++;
            if (done[1]) dcyc = cyc;
            tick();
        end
        checks++;
        if (dcyc - k0 != 27) begin
            failures++;
            $display("FAIL basic_done_time got=%0d want=27", dcyc - k0);
        end
        checks++;
        if (highs != 12) begin
            failures++;
            $display("FAIL basic_high_cycles got=%0d want=12", highs);
        end
    endtask

    task automatic test_edge_values();
        int k0, dcyc, highs;
        width = 16'd0; period = 16'd0; n_pulses = 8'd1; start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        checks++;
        if (pulse[2] !== 1'b1 || busy[2] !== 1'b1) begin
            failures++;
            $display("FAIL edge_w0_rise got=%b/%b want=1/1", pulse[2], busy[2]);
        end
        tick();
        checks++;
        if (pulse[2] !== 1'b0 || busy[2] !== 1'b0 || done[2] !== 1'b1) begin
            failures++;
            $display("FAIL edge_w0_done got=%b/%b/%b want=0/0/1", pulse[2], busy[2], done[2]);
        end
        tick();
        checks++;
        if (done[2] !== 1'b0) begin
            failures++;
            $display("FAIL edge_w0_done_clear got=%b want=0", done[2]);
        end
        width = 16'd5; period = 16'd5; n_pulses = 8'd2; start[3] = 1'b1;
        tick();
        k0 = cyc; dcyc = -1; highs = 0;
        start[3] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (pulse !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL edge_p_eq_w cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc, pulse, busy, done, ep, eb, ed);
            end
            if (pulse[3]) highs++;
            if (done[3]) dcyc = cyc;
            tick();
        end
        checks++;
        if (dcyc - k0 != 11 || highs != 10) begin
            failures++;
            $display("FAIL edge_p_eq_w_timing got=%0d,%0d want=11,10", dcyc - k0, highs);
        end
    endtask

    task automatic test_continuous_stop();
        int highs, any_done;
        highs = 0; any_done = 0;
        width = 16'd2; period = 16'd4; n_pulses = 8'd0; start[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            start[2] = 1'b0;
            checks++;
            if (pulse !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL cont cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc, pulse, busy, done, ep, eb, ed);
            end
            if (pulse[2]) highs++;
            if (done[2]) any_done++;
        end
        checks++;
        if (highs != 10) begin
            failures++;
            $display("FAIL cont_high_cycles got=%0d want=10", highs);
        end
        repeat ($urandom_range(0, 5)) tick();
        stop[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            stop[2] = 1'b0;
            checks++;
            if (pulse[2] !== 1'b0 || busy[2] !== 1'b0 || pulse !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL stop cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc, pulse, busy, done, ep, eb, ed);
            end
            if (done[2]) any_done++;
        end
        checks++;
        if (any_done != 0) begin
            failures++;
            $display("FAIL cont_no_done got=%0d want=0", any_done);
        end
        start[2] = 1'b1; stop[2] = 1'b1;
        tick();
        start[2] = 1'b0; stop[2] = 1'b0;
        tick();
        checks++;
        if (busy[2] !== 1'b0 || pulse[2] !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_same got=%b/%b want=0/0", pulse[2], busy[2]);
        end
    endtask

    task automatic test_shadow();
        width = 16'd2; period = 16'd6; n_pulses = 8'd3; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        width = 16'd7; start[3] = 1'b1;
        tick();
        start[3] = 1'b0;
        for (int i = 0; i < 28; i++) begin
            width = 16'($urandom); period = 16'($urandom); n_pulses = 8'($urandom);
            checks++;
            if (pulse !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL shadow cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc, pulse, busy, done, ep, eb, ed);
            end
            tick();
        end
    endtask

    task automatic test_retrigger();
        int k0, dcyc, ndone;
        ndone = 0; dcyc = -1;
        width = 16'd3; period = 16'd8; n_pulses = 8'd4; start[1] = 1'b1;
        tick();
        k0 = cyc;
        start[1] = 1'b0;
        for (int i = 0; i < 44; i++) begin
            checks++;
            if (pulse !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL retrig cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc, pulse, busy, done, ep, eb, ed);
            end
            if (done[1]) begin ndone++; dcyc = cyc; end
            start[1] = (cyc - k0 == 8);
            tick();
        end
        start[1] = 1'b0;
        checks++;
        if (ndone != 1 || dcyc - k0 != (RETRIG ? 36 : 27)) begin
            failures++;
            $display("FAIL retrig_done got=%0d@%0d want=1@%0d", ndone, dcyc - k0, RETRIG ? 36 : 27);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            width    = 16'($urandom_range(0, 4));
            period   = 16'($urandom_range(0, 10));
            n_pulses = 8'($urandom_range(0, 3));
            for (int c = 0; c < NCH; c++) begin
                start[c] = ($urandom_range(0, 7) == 0);
                stop[c]  = ($urandom_range(0, 15) == 0);
            end
            tick();
            checks++;
            if (pulse !== ep || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b/%b/%b want=%b/%b/%b", cyc, pulse, busy, done, ep, eb, ed);
            end
        end
        start = '0; stop = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_edge_values();
        test_continuous_stop();
        test_shadow();
        test_retrigger();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
